fir_seq_mac: RTL and testbench

Parametrised time-multiplexed FIR filter: one signed multiplier and one accumulator iterate over NUM_TAPS coefficients per input sample. It is the generalised successor of the fixed 3-tap FIR, adding the following:
- Arbitrary tap count and widths.
- A ready/valid input handshake.
- A one-cycle output-valid strobe.
- Rounded and saturated output scaling.
- Runtime coefficient loading and delay-line history clear.
It sits between the sample source and the output register bank of the top-level design.

---
 rtl/fir_pkg.sv | 59 +++++
 rtl/fir_seq_mac_if.sv | 31 +++
 rtl/fir_mac_unit.sv | 42 ++++
 rtl/fir_seq_mac.sv | 149 ++++++++++++++
 tb/tb_fir_seq_mac.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the sequential-MAC FIR: state encoding, a
// constant-friendly clog2 and the round/saturate helper used on the
// accumulator before it reaches the output register.
package fir_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t CALC   = 2'd1;
    localparam state_t OUTPUT = 2'd2;
    localparam state_t CONFIG = 2'd3;

    // Working width for the round/saturate helper; wide enough for any
    // accumulator this block can be configured with.
    localparam int SAT_W = 128;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Round half up by 'shift' bits, then clamp to a signed 'width'-bit range.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] acc,
        input int                      shift,
        input int                      width
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] result;
        one = SAT_W'(1);
        s   = acc;
        if (shift > 0) begin
            s = s + (one <<< (shift - 1));
        end
        s     = s >>> shift;
        max_v = (one <<< (width - 1)) - one;
        min_v = -(one <<< (width - 1));
        if (s > max_v) begin
            result = max_v;
        end else if (s < min_v) begin
            result = min_v;
        end else begin
            result = s;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_seq_mac_if.sv
// Sample/control/result bundle between the sample source and the FIR.
//
// Handshake: a sample transfers on a rising clk edge where both
// s_axis_fir_tvalid and s_axis_fir_tready are high. tready is only high in
// IDLE with no coefficient-load or history-clear request pending; the
// source may hold tvalid high across busy cycles and the sample is taken
// on the first edge where tready is also high.
interface fir_seq_mac_if #(
    parameter int X_W = 8,
    parameter int Y_W = 16
);
    logic signed [X_W-1:0] x_n;
    logic                  s_axis_fir_tvalid;
    logic                  s_axis_fir_tready;
    logic                  s_set_coeffs;
    logic                  s_clear_hist;
    logic signed [Y_W-1:0] o_y_n;
    logic                  o_valid;
    logic                  o_busy;
    logic [1:0]            dbg_state;

    modport master (
        output x_n, s_axis_fir_tvalid, s_set_coeffs, s_clear_hist,
        input  s_axis_fir_tready, o_y_n, o_valid, o_busy, dbg_state
    );

    modport slave (
        input  x_n, s_axis_fir_tvalid, s_set_coeffs, s_clear_hist,
        output s_axis_fir_tready, o_y_n, o_valid, o_busy, dbg_state
    );
endinterface

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: acc <= 0 on clr, acc <= acc + a*b on en.
module fir_mac_unit #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Full-precision product, sign-extended into the accumulator width.
    always_comb begin
        prod  = P_W'(a) * P_W'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR: one MAC walks the tap bank once per accepted
// sample, then the rounded/saturated sum is registered onto o_y_n.
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int X_W       = 8,
    parameter int COEF_W    = 8,
    parameter int NUM_TAPS  = 8,
    parameter int Y_W       = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic          clk,
    input  logic          reset,
    fir_seq_mac_if.slave  bus
);
    localparam int              K_W    = clog2(NUM_TAPS);
    localparam int              ACC_W  = X_W + COEF_W + K_W;
    localparam logic [K_W-1:0]  K_LAST = K_W'(NUM_TAPS - 1);

    state_t                    state_q, state_d;
    logic signed [X_W-1:0]     buffs_q [NUM_TAPS];
    logic signed [X_W-1:0]     buffs_d [NUM_TAPS];
    logic signed [COEF_W-1:0]  taps_q  [NUM_TAPS];
    logic signed [COEF_W-1:0]  taps_d  [NUM_TAPS];
    logic [K_W-1:0]            k_q, k_d;
    logic signed [Y_W-1:0]     y_q, y_d;

    logic                      tready;
    logic                      accept;
    logic                      mac_clr;
    logic                      mac_en;
    logic signed [X_W-1:0]     mac_a;
    logic signed [COEF_W-1:0]  mac_b;
    logic signed [ACC_W-1:0]   acc;
    logic signed [SAT_W-1:0]   sat_full;
    logic                      sat_unused;

    fir_mac_unit #(
        .A_W   (X_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    // Scale the finished sum; only the low Y_W bits survive saturation.
    always_comb begin
        sat_full   = sat_round(SAT_W'(acc), OUT_SHIFT, Y_W);
        sat_unused = &{1'b0, sat_full[SAT_W-1:Y_W]};
    end

    // State register plus delay line, tap bank, tap counter and output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            y_q     <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                buffs_q[i] <= '0;
                taps_q[i]  <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            y_q     <= y_d;
            for (int i = 0; i < NUM_TAPS; i++) begin
                buffs_q[i] <= buffs_d[i];
                taps_q[i]  <= taps_d[i];
            end
        end
    end

    // Next state and datapath updates; requests outside IDLE/CONFIG are dropped.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        y_d     = y_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_a   = buffs_q[k_q];
        mac_b   = taps_q[k_q];
        for (int i = 0; i < NUM_TAPS; i++) begin
            buffs_d[i] = buffs_q[i];
            taps_d[i]  = taps_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.s_set_coeffs) begin
                    state_d = CONFIG;
                end else if (bus.s_clear_hist) begin
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        buffs_d[i] = '0;
                    end
                end else if (accept) begin
                    for (int i = 1; i < NUM_TAPS; i++) begin
                        buffs_d[i] = buffs_q[i-1];
                    end
                    buffs_d[0] = bus.x_n;
                    mac_clr    = 1'b1;
                    k_d        = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = OUTPUT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            OUTPUT: begin
                y_d     = sat_full[Y_W-1:0];
                state_d = IDLE;
            end
            CONFIG: begin
                if (bus.s_set_coeffs) begin
                    for (int i = 1; i < NUM_TAPS; i++) begin
                        taps_d[i] = taps_q[i-1];
                    end
                    taps_d[0] = bus.x_n[COEF_W-1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs, decoded from the current state.
    always_comb begin
        tready = (state_q == IDLE) && !bus.s_set_coeffs && !bus.s_clear_hist && !reset;
        accept = tready && bus.s_axis_fir_tvalid;
        bus.s_axis_fir_tready = tready;
        bus.o_valid           = (state_q == OUTPUT);
        bus.o_busy            = (state_q != IDLE);
        bus.o_y_n             = y_q;
        bus.dbg_state         = state_q;
    end
endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac: a sum-of-products model predicts every
// result and the cycle its strobe appears; a compare process checks the
// outputs each cycle, and the tests pin known values on top of that.
module tb_fir_seq_mac;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_seq_mac_if #(.X_W(8), .Y_W(16)) bus_a ();
    fir_seq_mac_if #(.X_W(8), .Y_W(16)) bus_b ();

    fir_seq_mac #(.X_W(8), .COEF_W(8), .NUM_TAPS(N), .Y_W(16), .OUT_SHIFT(0))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    fir_seq_mac #(.X_W(8), .COEF_W(8), .NUM_TAPS(N), .Y_W(16), .OUT_SHIFT(2))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic              tv [2];
    logic              set_c [2];
    logic              clr_h [2];
    logic signed [7:0] xd [2];
    logic              ready_w [2];
    logic              valid_w [2];
    logic              busy_w [2];
    logic signed [15:0] y_w [2];
    logic [1:0]        st_w [2];

    assign bus_a.x_n = xd[0];
    assign bus_a.s_axis_fir_tvalid = tv[0];
    assign bus_a.s_set_coeffs = set_c[0];
    assign bus_a.s_clear_hist = clr_h[0];
    assign bus_b.x_n = xd[1];
    assign bus_b.s_axis_fir_tvalid = tv[1];
    assign bus_b.s_set_coeffs = set_c[1];
    assign bus_b.s_clear_hist = clr_h[1];
    assign ready_w[0] = bus_a.s_axis_fir_tready;
    assign valid_w[0] = bus_a.o_valid;
    assign busy_w[0]  = bus_a.o_busy;
    assign y_w[0]     = bus_a.o_y_n;
    assign st_w[0]    = bus_a.dbg_state;
    assign ready_w[1] = bus_b.s_axis_fir_tready;
    assign valid_w[1] = bus_b.o_valid;
    assign busy_w[1]  = bus_b.o_busy;
    assign y_w[1]     = bus_b.o_y_n;
    assign st_w[1]    = bus_b.dbg_state;

    // Model state: taps and history as plain integers, expected results as
    // {strobe cycle, value} entries.
    int          m_taps [2][N];
    int          m_buf  [2][N];
    logic [47:0] exp_q0 [$];
    logic [47:0] exp_q1 [$];
    longint      hold_y [2];
    longint      pend_y [2];
    bit          pend   [2];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint model_y(input int d);
        longint acc;
        int     sh;
        acc = 0;
        sh  = (d == 0) ? 0 : 2;
        for (int i = 0; i < N; i++) acc += longint'(m_taps[d][i]) * longint'(m_buf[d][i]);
        if (sh > 0) acc += longint'(1 << (sh - 1));
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_taps[d][i] = (i == 0) ? 1 : 0;
                m_buf[d][i]  = 0;
            end
            hold_y[d] = 0;
            pend_y[d] = 0;
            pend[d]   = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic push_exp(input int d, input longint y, input int vcyc);
        logic [31:0]        c32;
        logic signed [15:0] y16;
        c32 = vcyc;
        y16 = 16'(y);
        if (d == 0) exp_q0.push_back({c32, y16});
        else        exp_q1.push_back({c32, y16});
    endtask

    // Present a sample until it is accepted; returns the accepting edge's cycle.
    task automatic send(input int d, input int x, output int acc_cyc);
        bit   done;
        int   tries;
        logic rdy;
        done = 1'b0;
        tries = 0;
        acc_cyc = -1;
        @(negedge clk);
        tv[d] = 1'b1;
        xd[d] = 8'(x);
        while (!done && tries < 50) begin
            #1 rdy = ready_w[d];
            @(posedge clk);
            if (rdy) begin
                acc_cyc = cyc;
                done = 1'b1;
                for (int i = N - 1; i > 0; i--) m_buf[d][i] = m_buf[d][i-1];
                m_buf[d][0] = x;
                push_exp(d, model_y(d), cyc + N + 1);
            end
            @(negedge clk);
            tries++;
        end
        tv[d] = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_result(input int d, output longint y, output int vcyc);
        int n;
        n = 0;
        y = 0;
        vcyc = -1;
        while (!valid_w[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!valid_w[d]) begin
            check("result_timeout", 0, 1);
        end else begin
            vcyc = cyc;
            @(negedge clk);
            y = y_w[d];
        end
    endtask

    task automatic send_check(input int d, input int x, input longint exp_y, input string name);
        int     ac;
        int     vc;
        longint y;
        send(d, x, ac);
        wait_result(d, y, vc);
        check(name, y, exp_y);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy_w[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy_w[d], 0);
    endtask

    task automatic load_coeffs(input int d, input int w[N]);
        wait_idle(d);
        @(negedge clk);
        set_c[d] = 1'b1;
        tv[d] = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            xd[d] = 8'(w[i]);
            #1 check("busy_in_config", busy_w[d], 1);
            for (int j = N - 1; j > 0; j--) m_taps[d][j] = m_taps[d][j-1];
            m_taps[d][0] = w[i];
        end
        @(negedge clk);
        set_c[d] = 1'b0;
        @(negedge clk);
        #1 check("idle_after_config", busy_w[d], 0);
    endtask

    task automatic clear_hist(input int d);
        wait_idle(d);
        @(negedge clk);
        clr_h[d] = 1'b1;
        tv[d] = 1'b1;
        xd[d] = 8'sd99;
        #1 check("ready_low_on_clear", ready_w[d], 0);
        @(negedge clk);
        clr_h[d] = 1'b0;
        tv[d] = 1'b0;
        for (int i = 0; i < N; i++) m_buf[d][i] = 0;
    endtask

    // Per-cycle comparison of both DUTs against the model.
    logic [47:0] cmp_head;
    bit          cmp_have;
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (pend[d]) begin
                    check("y_update", y_w[d], pend_y[d]);
                    hold_y[d] = pend_y[d];
                    pend[d] = 1'b0;
                end else begin
                    check("y_hold", y_w[d], hold_y[d]);
                end
                check("ready_while_busy", busy_w[d] & ready_w[d], 0);
                cmp_have = 1'b0;
                if (d == 0 && exp_q0.size() > 0) begin cmp_have = 1'b1; cmp_head = exp_q0[0]; end
                if (d == 1 && exp_q1.size() > 0) begin cmp_have = 1'b1; cmp_head = exp_q1[0]; end
                if (cmp_have && longint'(cmp_head[47:16]) < longint'(cyc)) begin
                    check("missed_valid", 0, 1);
                    if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                    cmp_have = 1'b0;
                end
                if (valid_w[d]) begin
                    if (!cmp_have) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        check("valid_cycle", cyc, cmp_head[47:16]);
                        if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                        pend_y[d] = longint'(signed'(cmp_head[15:0]));
                        pend[d] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int     w[N];
        int     ac;
        int     vc;
        longint y;
        int     exp2[N];
        for (int d = 0; d < 2; d++) begin
            tv[d] = 1'b0; set_c[d] = 1'b0; clr_h[d] = 1'b0; xd[d] = '0;
        end
        model_reset();
        reset = 1'b1;
        #23;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", ready_w[d], 0);
            check("rst_busy", busy_w[d], 0);
            check("rst_valid", valid_w[d], 0);
            check("rst_y", y_w[d], 0);
            check("rst_state", st_w[d], 0);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1 check("ready_after_rst", ready_w[0], 1);

        // Pass-through after reset, with latency and tready during CALC.
        send(0, 5, ac);
        #1 check("ready_low_calc", ready_w[0], 0);
        wait_result(0, y, vc);
        check("pt_5", y, 5);
        check("latency", vc - ac, N + 1);
        send_check(0, -3, -3, "pt_m3");

        // Rounding on the OUT_SHIFT=2 instance.
        send_check(1, 6, 2, "rnd_6");
        send_check(1, -6, -1, "rnd_m6");
        send_check(1, 5, 1, "rnd_5");
        send_check(1, -7, -2, "rnd_m7");

        // Coefficient load order and impulse response.
        w = '{1, 2, 3, 4, 0, 0, 0, 0};
        load_coeffs(0, w);
        clear_hist(0);
        exp2 = '{0, 0, 0, 0, 4, 3, 2, 1};
        for (int j = 0; j < N; j++) send_check(0, (j == 0) ? 1 : 0, exp2[j], "impulse");

        // Saturation both ways.
        w = '{127, 127, 127, 127, 127, 127, 127, 127};
        load_coeffs(0, w);
        y = 0;
        for (int j = 0; j < N; j++) begin
            send(0, 127, ac);
            wait_result(0, y, vc);
        end
        check("sat_pos", y, 32767);
        for (int j = 0; j < N; j++) begin
            send(0, -128, ac);
            wait_result(0, y, vc);
        end
        check("sat_neg", y, -32768);

        // Priority of set_coeffs over a sample, and requests ignored while busy.
        w = '{0, 0, 0, 0, 0, 0, 1, 1};
        load_coeffs(0, w);
        clear_hist(0);
        send_check(0, 10, 10, "two_tap_10");
        @(negedge clk);
        set_c[0] = 1'b1; tv[0] = 1'b1; xd[0] = 8'sd77;
        #1 check("ready_low_set", ready_w[0], 0);
        @(negedge clk);
        set_c[0] = 1'b0; tv[0] = 1'b0;
        #1 check("config_entered", busy_w[0], 1);
        @(negedge clk);
        #1 check("config_left", busy_w[0], 0);
        send_check(0, 20, 30, "no_accept_on_set");
        send(0, 3, ac);
        set_c[0] = 1'b1; clr_h[0] = 1'b1; tv[0] = 1'b1; xd[0] = 8'sd50;
        #1 check("busy_ignores_req", ready_w[0], 0);
        @(negedge clk);
        set_c[0] = 1'b0; clr_h[0] = 1'b0; tv[0] = 1'b0;
        wait_result(0, y, vc);
        check("calc_ignores_req", y, 23);
        send_check(0, 4, 7, "taps_hist_kept");

        // Reset in the third CALC cycle.
        send(0, 40, ac);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("midrst_busy", busy_w[0], 0);
        check("midrst_valid", valid_w[0], 0);
        check("midrst_y", y_w[0], 0);
        @(posedge clk);
        #2 reset = 1'b0;
        send_check(0, 9, 9, "post_rst_9");
        send_check(0, -3, -3, "post_rst_m3");

        repeat (15) @(negedge clk);
        check("exp_q0_empty", exp_q0.size(), 0);
        check("exp_q1_empty", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
